// File: rtl/peripheral_timer_bank.sv
// Peripheral timer bank: ID, control, status, 64-bit free-running cycle
// counter with a high-word snapshot, a reloadable down-counting timer with
// a sticky expiry flag and interrupt, and a scratch register. Accessed over
// a single-cycle request port. Read data is registered one edge after the
// request.
module peripheral_timer_bank #(
  parameter int          ADDR_W   = 27,
  parameter logic [31:0] ID_VALUE = 32'h5045_5231
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              req_i,
  input  logic              rw_i,
  input  logic [ADDR_W-1:0] add_i,
  input  logic [31:0]       data_i,
  output logic [31:0]       data_o,
  output logic              irq_o
);

  localparam logic [2:0] SEL_ID     = 3'd0;
  localparam logic [2:0] SEL_CTRL   = 3'd1;
  localparam logic [2:0] SEL_STATUS = 3'd2;
  localparam logic [2:0] SEL_LO     = 3'd3;
  localparam logic [2:0] SEL_HI     = 3'd4;
  localparam logic [2:0] SEL_LOAD   = 3'd5;
  localparam logic [2:0] SEL_COUNT  = 3'd6;
  localparam logic [2:0] SEL_SCR    = 3'd7;

  logic [3:0]  ctrl;
  logic        expired;
  logic        snap_valid;
  logic [63:0] cycle_cnt;
  logic [31:0] cycle_hi_snap;
  logic [31:0] timer_load;
  logic [31:0] timer_count;
  logic [31:0] scratch;
  logic [31:0] rdata;

  logic [2:0] sel;
  logic       rd_en;
  logic       wr_en;
  logic       timer_dec;
  logic       timer_expire;
  logic       timer_reload;
  logic       unused_addr_bits;

  // Only add_i[4:2] selects a register; the remaining address bits are don't-care.
  assign sel              = add_i[4:2];
  assign unused_addr_bits = ^{add_i[ADDR_W-1:5], add_i[1:0]};
  assign rd_en            = req_i & ~rw_i;
  assign wr_en            = req_i & rw_i;

  // The timer only moves while enabled; expiry is the 1->0 step itself, so a
  // zero reload value never re-expires, and a load write suppresses the step.
  assign timer_dec    = ctrl[1] && (timer_count != 32'd0);
  assign timer_expire = ctrl[1] && (timer_count == 32'd1) && !(wr_en && sel == SEL_LOAD);
  assign timer_reload = ctrl[1] && ctrl[2] && (timer_count == 32'd0);

  // Read mux over the pre-edge register state.
  always_comb begin
    rdata = 32'd0;
    case (sel)
      SEL_ID:     rdata = ID_VALUE;
      SEL_CTRL:   rdata = {28'd0, ctrl};
      SEL_STATUS: rdata = {30'd0, snap_valid, expired};
      SEL_LO:     rdata = cycle_cnt[31:0];
      SEL_HI:     rdata = cycle_hi_snap;
      SEL_LOAD:   rdata = timer_load;
      SEL_COUNT:  rdata = timer_count;
      SEL_SCR:    rdata = scratch;
      default:    rdata = 32'd0;
    endcase
  end

  // Control and scratch registers.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      ctrl    <= 4'd0;
      scratch <= 32'd0;
    end else if (wr_en) begin
      if (sel == SEL_CTRL) ctrl    <= data_i[3:0];
      if (sel == SEL_SCR)  scratch <= data_i;
    end
  end

  // Cycle counter: a write to CYCLE_LO clears it and takes priority over counting.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      cycle_cnt <= 64'd0;
    end else if (wr_en && sel == SEL_LO) begin
      cycle_cnt <= 64'd0;
    end else if (ctrl[0]) begin
      cycle_cnt <= cycle_cnt + 64'd1;
    end
  end

  // High-word snapshot is captured by a CYCLE_LO read and consumed by a CYCLE_HI read.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      cycle_hi_snap <= 32'd0;
      snap_valid    <= 1'b0;
    end else if (rd_en && sel == SEL_LO) begin
      cycle_hi_snap <= cycle_cnt[63:32];
      snap_valid    <= 1'b1;
    end else if (rd_en && sel == SEL_HI) begin
      snap_valid    <= 1'b0;
    end
  end

  // Timer: load write beats auto-reload, which beats the decrement.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      timer_load  <= 32'd0;
      timer_count <= 32'd0;
    end else if (wr_en && sel == SEL_LOAD) begin
      timer_load  <= data_i;
      timer_count <= data_i;
    end else if (timer_reload) begin
      timer_count <= timer_load;
    end else if (timer_dec) begin
      timer_count <= timer_count - 32'd1;
    end
  end

  // Sticky expiry flag: a new expiry wins over a coincident write-one-to-clear.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      expired <= 1'b0;
    end else if (timer_expire) begin
      expired <= 1'b1;
    end else if (wr_en && sel == SEL_STATUS && data_i[0]) begin
      expired <= 1'b0;
    end
  end

  // Registered read data (held across writes) and interrupt.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      data_o <= 32'd0;
      irq_o  <= 1'b0;
    end else begin
      if (rd_en) data_o <= rdata;
      irq_o <= expired & ctrl[3];
    end
  end

endmodule

// File: tb/tb_peripheral_timer_bank.sv
// Directed bench for peripheral_timer_bank: a table of register accesses
// followed by hand-timed sequences for the counter, timer and reset cases.
module tb_peripheral_timer_bank;

  localparam int          ADDR_W = 27;
  localparam logic [31:0] ID     = 32'h5045_5231;

  logic              clk = 1'b0;
  logic              rst;
  logic              req;
  logic              rw;
  logic [ADDR_W-1:0] add;
  logic [31:0]       wdata;
  logic [31:0]       data_o;
  logic              irq_o;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wd;
    logic [31:0]       exp_v;
    string             nm;
  } vec_t;

  vec_t vq[$];

  peripheral_timer_bank #(.ADDR_W(ADDR_W), .ID_VALUE(ID)) dut (
    .clock_i (clk),
    .reset_i (rst),
    .req_i   (req),
    .rw_i    (rw),
    .add_i   (add),
    .data_i  (wdata),
    .data_o  (data_o),
    .irq_o   (irq_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp_v);
    end
  endtask

  task automatic tv(input logic r, input logic [ADDR_W-1:0] a, input logic [31:0] d,
                    input logic [31:0] e, input string nm);
    vec_t v;
    v.rw = r; v.addr = a; v.wd = d; v.exp_v = e; v.nm = nm;
    vq.push_back(v);
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    @(negedge clk);
    req = 1'b1; rw = 1'b1; add = a; wdata = d;
    @(negedge clk);
    req = 1'b0; rw = 1'b0;
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a, output logic [31:0] rd);
    @(negedge clk);
    req = 1'b1; rw = 1'b0; add = a;
    @(posedge clk);
    #1;
    rd = data_o;
    req = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    rst = 1'b1; req = 1'b0; rw = 1'b0; add = '0; wdata = '0;

    // Register map table.
    tv(1'b0, 27'h00, 32'h0, ID,            "id");
    tv(1'b0, 27'h04, 32'h0, 32'h0,         "ctrl_rst");
    tv(1'b0, 27'h08, 32'h0, 32'h0,         "status_rst");
    tv(1'b0, 27'h0C, 32'h0, 32'h0,         "lo_rst");
    tv(1'b0, 27'h14, 32'h0, 32'h0,         "load_rst");
    tv(1'b0, 27'h1C, 32'h0, 32'h0,         "scratch_rst");
    tv(1'b1, 27'h1C, 32'hA5A5_1234, 32'h0, "");
    tv(1'b0, 27'h1C, 32'h0, 32'hA5A5_1234, "scratch_rw");
    tv(1'b1, 27'h04, 32'hFFFF_FFF4, 32'h0, "");
    tv(1'b0, 27'h04, 32'h0, 32'h4,         "ctrl_mask");
    tv(1'b1, 27'h00, 32'h0, 32'h0,         "");
    tv(1'b0, 27'h00, 32'h0, ID,            "id_ro");
    tv(1'b1, 27'h14, 32'h10, 32'h0,        "");
    tv(1'b0, 27'h14, 32'h0, 32'h10,        "load_rw");
    tv(1'b0, 27'h18, 32'h0, 32'h10,        "count_load");
    tv(1'b1, 27'h18, 32'h7, 32'h0,         "");
    tv(1'b0, 27'h18, 32'h0, 32'h10,        "count_ro");
    tv(1'b1, 27'h10, 32'h1234, 32'h0,      "");
    tv(1'b0, 27'h10, 32'h0, 32'h0,         "hi_ro");
    tv(1'b0, 27'h021, 32'h0, ID,           "alias_low");
    tv(1'b0, 27'h7FF_FFFF, 32'h0, 32'hA5A5_1234, "alias_high");
    tv(1'b1, 27'h400_0006, 32'h0, 32'h0,   "");
    tv(1'b0, 27'h04, 32'h0, 32'h0,         "ctrl_clear");
    tv(1'b1, 27'h14, 32'h0, 32'h0,         "");
    tv(1'b0, 27'h18, 32'h0, 32'h0,         "count_zero");

    repeat (3) @(negedge clk);
    check("rst_data", data_o, 32'h0);
    check("rst_irq", {31'd0, irq_o}, 32'h0);
    rst = 1'b0;

    foreach (vq[i]) begin
      if (vq[i].rw) do_write(vq[i].addr, vq[i].wd);
      else begin
        do_read(vq[i].addr, rd);
        check(vq[i].nm, rd, vq[i].exp_v);
      end
    end
    check("irq_idle", {31'd0, irq_o}, 32'h0);

    // Cycle counter runs for a known window; snapshot flag toggles.
    do_write(27'h04, 32'h1);
    repeat (10) @(negedge clk);
    do_read(27'h0C, rd);
    n_cmp++;
    if (rd < 32'd10 || rd > 32'd12) begin
      n_fail++;
      $display("FAIL cyc_lo_range: got %0d, expected 10..12", rd);
    end
    do_read(27'h08, rd); check("snap_valid_set", rd, 32'h2);
    do_read(27'h10, rd); check("cyc_hi_zero", rd, 32'h0);
    do_read(27'h08, rd); check("snap_valid_clr", rd, 32'h0);
    do_write(27'h04, 32'h0);

    // Preset the counter just below a low-word carry.
    @(negedge clk);
    force dut.cycle_cnt = 64'h0000_0005_FFFF_FFFD;
    @(negedge clk);
    release dut.cycle_cnt;
    do_read(27'h0C, rd); check("pre_wrap_lo", rd, 32'hFFFF_FFFD);
    do_read(27'h10, rd); check("pre_wrap_hi", rd, 32'h5);
    do_write(27'h04, 32'h1);
    repeat (4) @(negedge clk);
    do_read(27'h0C, rd); check("post_wrap_lo", rd, 32'h2);
    do_read(27'h10, rd); check("post_wrap_hi", rd, 32'h6);
    do_write(27'h0C, 32'h0);
    do_read(27'h0C, rd); check("lo_after_clear", rd, 32'h1);
    do_read(27'h10, rd); check("hi_after_clear", rd, 32'h0);
    do_write(27'h04, 32'h0);

    // One-shot countdown from 5 with interrupt, watched by back-to-back reads.
    do_write(27'h14, 32'h5);
    do_write(27'h04, 32'hA);
    req = 1'b1; rw = 1'b0; add = 27'h18;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("count_seq%0d", k), data_o, (k <= 6) ? 32'(6 - k) : 32'h0);
      if (k == 5) check("irq_lag", {31'd0, irq_o}, 32'h0);
      if (k == 6) check("irq_set", {31'd0, irq_o}, 32'h1);
    end
    req = 1'b0;
    do_read(27'h08, rd); check("expired_set", rd, 32'h1);
    @(negedge clk);
    req = 1'b1; rw = 1'b1; add = 27'h08; wdata = 32'h1;
    @(posedge clk);
    #1;
    req = 1'b0; rw = 1'b0;
    check("irq_hold_w1c", {31'd0, irq_o}, 32'h1);
    @(posedge clk);
    #1;
    check("irq_drop", {31'd0, irq_o}, 32'h0);
    check("data_hold_on_write", data_o, 32'h1);

    // Zero reload value with auto-reload never expires.
    do_write(27'h14, 32'h0);
    do_write(27'h04, 32'h6);
    repeat (6) @(negedge clk);
    do_read(27'h08, rd); check("zero_load_no_expire", rd, 32'h0);
    do_read(27'h18, rd); check("zero_load_count", rd, 32'h0);

    // Auto-reload from 3 with a W1C on the expiry edge.
    @(negedge clk);
    req = 1'b1; rw = 1'b1; add = 27'h14; wdata = 32'h3;
    @(posedge clk); #1;
    rw = 1'b0; add = 27'h18;
    @(posedge clk); #1;
    check("reload_seq3", data_o, 32'h3);
    @(posedge clk); #1;
    check("reload_seq2", data_o, 32'h2);
    rw = 1'b1; add = 27'h08; wdata = 32'h1;
    @(posedge clk); #1;
    rw = 1'b0; add = 27'h18;
    @(posedge clk); #1;
    check("reload_seq0", data_o, 32'h0);
    @(posedge clk); #1;
    check("reload_seq3b", data_o, 32'h3);
    add = 27'h08;
    @(posedge clk); #1;
    check("set_beats_w1c", data_o, 32'h1);
    req = 1'b0;
    do_write(27'h04, 32'h0);

    // Asynchronous reset in the middle of a countdown.
    do_write(27'h14, 32'd100);
    do_write(27'h04, 32'hA);
    do_read(27'h00, rd);
    check("pre_rst_data", data_o, ID);
    check("pre_rst_irq", {31'd0, irq_o}, 32'h1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_data", data_o, 32'h0);
    check("async_rst_irq", {31'd0, irq_o}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    req = 1'b1; rw = 1'b0; add = 27'h00;
    @(posedge clk); #1;
    req = 1'b0;
    check("first_req_after_rst", data_o, ID);
    do_read(27'h18, rd); check("count_after_rst", rd, 32'h0);
    do_read(27'h14, rd); check("load_after_rst", rd, 32'h0);
    do_read(27'h04, rd); check("ctrl_after_rst", rd, 32'h0);
    do_read(27'h08, rd); check("status_after_rst", rd, 32'h0);
    do_read(27'h0C, rd); check("lo_after_rst", rd, 32'h0);
    do_read(27'h1C, rd); check("scratch_after_rst", rd, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
